cbus_arbiter: RTL and testbench

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/common_pkg.sv | 35 +++
 rtl/cbus_arbiter_rr_select.sv | 28 ++
 rtl/cbus_arbiter.sv | 92 +++++++++
 tb/tb_cbus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared CBus transaction types used by the cache-side masters, the arbiter
// and the memory bridge.
package common;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_t;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2,
    SIZE_8B = 2'd3
  } cbus_size_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    cbus_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Combinational round-robin picker: first set bit of 'valid' found by
// scanning upward from 'ptr' and wrapping at NUM_REQ.
module rr_select #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IW = $clog2(NUM_REQ);

  // Scan from the farthest offset down so the nearest candidate assigns last
  always_comb begin
    int cand;
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (valid[cand[IW-1:0]]) begin
        found = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter funnelling several upstream CBus masters onto a single
// downstream slave, holding ownership for a whole burst.
module cbus_arbiter
  import common::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  cbus_req_t                  ireqs  [NUM_REQ],
  output cbus_resp_t                 iresps [NUM_REQ],
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 oresp,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE    = 1'b0,
    FORWARD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] req_valid;
  logic            sel_found;
  logic [IW-1:0]   sel_index;
  logic            done;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  rr_select #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_select (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .found(sel_found),
    .index(sel_index)
  );

  assign done = (state == FORWARD) && oresp.ready && oresp.last;

  // The completion edge always lands in IDLE, so a new grant never shares
  // the cycle in which the previous burst finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && sel_found) begin
        grant_idx <= sel_index;
      end
      if (done) begin
        rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_found) state_next = FORWARD;
      FORWARD: if (done)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the owner sees the slave; everyone else reads ready=0 and waits
  always_comb begin
    oreq = '0;
    busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end
    if (state == FORWARD) begin
      busy              = 1'b1;
      oreq              = ireqs[grant_idx];
      iresps[grant_idx] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: a per-cycle vector table for the common
// paths plus hand-written fairness, mid-burst hold and reset-abort sequences.
module tb_cbus_arbiter;
  import common::*;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic [0:0] grant_idx;
  logic       busy;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit r0v;
    bit r1v;
    bit rdy;
    bit lst;
    bit busy;
    int grant;
    bit ov;
    bit route0;
    bit route1;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .ireqs    (ireqs),
    .iresps   (iresps),
    .oreq     (oreq),
    .oresp    (oresp),
    .grant_idx(grant_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit r0v, input bit r1v, input bit rdy,
                               input bit lst, input bit rst);
    ireqs[0].valid = r0v;
    ireqs[1].valid = r1v;
    oresp.ready    = rdy;
    oresp.last     = lst;
    reset          = rst;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic checkVector(input int i, input vec_t v);
    cbus_req_t  exp_req;
    cbus_resp_t zero_resp;
    zero_resp = '0;
    exp_req   = v.busy ? ireqs[v.grant] : '0;
    checkOutput($sformatf("v%0d.busy", i), 128'(busy), 128'(v.busy));
    if (v.busy) checkOutput($sformatf("v%0d.grant", i), 128'(grant_idx), 128'(v.grant));
    checkOutput($sformatf("v%0d.oreq_valid", i), 128'(oreq.valid), 128'(v.ov));
    checkOutput($sformatf("v%0d.oreq", i), 128'(oreq), 128'(exp_req));
    checkOutput($sformatf("v%0d.iresp0", i), 128'(iresps[0]),
                128'(v.route0 ? oresp : zero_resp));
    checkOutput($sformatf("v%0d.iresp1", i), 128'(iresps[1]),
                128'(v.route1 ? oresp : zero_resp));
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    ireqs[0] = '{valid: 1'b0, is_write: 1'b1, size: SIZE_8B, addr: 32'h1000_0000,
                 strobe: 8'hFF, data: 64'hA0A0_A0A0_0000_0001, len: 8'd0,
                 burst: BURST_FIXED};
    ireqs[1] = '{valid: 1'b0, is_write: 1'b0, size: SIZE_4B, addr: 32'h8000_0000,
                 strobe: 8'h0F, data: 64'h0, len: 8'd3, burst: BURST_INCR};
    oresp    = '{ready: 1'b0, last: 1'b0, data: 64'hDEAD_BEEF_0123_4567};
    reset    = 1'b1;

    //            r0v r1v rdy lst busy g  ov  rt0 rt1
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 1, 0, 1, 1, 1, 0, 1};
    vecs[3]  = '{0, 1, 1, 0, 1, 1, 1, 0, 1};
    vecs[4]  = '{0, 1, 1, 0, 1, 1, 1, 0, 1};
    vecs[5]  = '{0, 1, 1, 1, 1, 1, 1, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 1, 1, 1, 0, 1};
    vecs[13] = '{0, 1, 1, 1, 1, 1, 1, 0, 1};
    vecs[14] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
    vecs[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
    vecs[18] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    vecs[20] = '{0, 0, 1, 1, 1, 0, 0, 1, 0};
    vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    doReset();
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].r0v, vecs[i].r1v, vecs[i].rdy, vecs[i].lst, 0);
      checkVector(i, vecs[i]);
      tick();
    end

    // Fairness: both masters keep requesting single-beat FIXED transfers
    doReset();
    for (int t = 0; t < 6; t++) begin
      int w;
      w = 0;
      applyStimulus(1, 1, 0, 0, 0);
      while (!busy && w < 4) begin
        tick();
        w++;
      end
      if (!busy) begin
        checks++;
        $display("[TB] FAIL fair%0d.timeout: got busy=0 expected busy=1 within 4 cycles", t);
      end else begin
        checkOutput($sformatf("fair%0d.grant", t), 128'(grant_idx), 128'(t % 2));
        applyStimulus(1, 1, 1, 1, 0);
        tick();
      end
    end

    // Mid-burst hold: requester 1 shows up during beat 2 of an 8-beat burst
    doReset();
    ireqs[0].len   = 8'd7;
    ireqs[0].burst = BURST_INCR;
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    for (int b = 1; b <= 8; b++) begin
      applyStimulus(1, b >= 2, 1, b == 8, 0);
      checkOutput($sformatf("hold.beat%0d.busy", b), 128'(busy), 128'(1));
      checkOutput($sformatf("hold.beat%0d.grant", b), 128'(grant_idx), 128'(0));
      tick();
    end
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("hold.idle_gap.busy", 128'(busy), 128'(0));
    tick();
    checkOutput("hold.switch.busy", 128'(busy), 128'(1));
    checkOutput("hold.switch.grant", 128'(grant_idx), 128'(1));
    applyStimulus(0, 1, 1, 1, 0);
    tick();
    ireqs[0].len   = 8'd0;
    ireqs[0].burst = BURST_FIXED;

    // Reset mid-burst: move rr_ptr to 1 first so the reset value is observable
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("rst.pre.grant", 128'(grant_idx), 128'(0));
    tick();
    ireqs[1].len = 8'd7;
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    for (int b = 1; b <= 2; b++) begin
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput($sformatf("rst.beat%0d.grant", b), 128'(grant_idx), 128'(1));
      tick();
    end
    applyStimulus(0, 1, 1, 0, 1);
    tick();
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("rst.after.busy", 128'(busy), 128'(0));
    checkOutput("rst.after.oreq_valid", 128'(oreq.valid), 128'(0));
    checkOutput("rst.after.grant_idx", 128'(grant_idx), 128'(0));
    checkOutput("rst.after.iresp1", 128'(iresps[1]), 128'(0));
    tick();
    checkOutput("rst.regrant.busy", 128'(busy), 128'(1));
    checkOutput("rst.regrant.grant", 128'(grant_idx), 128'(0));
    applyStimulus(1, 1, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
